// File: rtl/dac_pkg.sv
// Shared state encoding, DAC command-word layout and init-frame word for the DAC command arbiter.
// Holds types and constants only, so it adds no timing and no flow control.
package dac_pkg;

    localparam int COMM_W = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } dac_state_t;

    typedef struct packed {
        logic [COMM_W-1:0] comm;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dac_cmd_t;

    localparam dac_cmd_t INIT_CMD = '{comm: 4'h7, addr: 4'hF, data: 16'h0000};

    // The counter must reach n itself, so size it for n+1 values.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dac_rr_arb.sv
// Combinational round-robin one-hot selector. The search starts one above i_ptr, the last winner.
// Zero latency and no state; the caller owns the pointer and advances it only when it issues a grant.
module dac_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_vld
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = PW'((int'(i_ptr) + k) % NREQ);
            if (!o_vld && i_req[w_cand]) begin
                o_vld         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_cmd_arbiter.sv
// Round-robin arbiter feeding one command word at a time to a DAC SPI serializer. Latency: req to gnt is 1 clk, gnt to dac_start is 1 clk.
// Requesters are held off while a frame, its timeout or the inter-frame gap runs. Defining DAC_ARB_INIT_EN adds one init frame after reset.
module dac_cmd_arbiter
    import dac_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 64,
    parameter int TMO_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [COMM_W*NREQ-1:0]   i_req_comm,
    input  logic [ADDR_W*NREQ-1:0]   i_req_addr,
    input  logic [DATA_W*NREQ-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_gnt,
    output logic [COMM_W-1:0]        o_dac_comm,
    output logic [ADDR_W-1:0]        o_dac_addr,
    output logic [DATA_W-1:0]        o_dac_data,
    output logic                     o_dac_start,
    input  logic                     i_dac_busy,
    output logic                     o_busy,
    output logic                     o_err_tmo
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = cnt_width(TMO_CYCLES);
    localparam int GW = cnt_width(GAP_CYCLES);

    localparam logic [TW-1:0] TMO_LAST = (TMO_CYCLES > 0) ? TW'(TMO_CYCLES - 1) : '0;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    dac_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [TW-1:0]   r_tmo_cnt;
    logic [GW-1:0]   r_gap_cnt;
`ifdef DAC_ARB_INIT_EN
    logic            r_init_pend;
`endif

    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_win;
    logic            w_any;
    dac_cmd_t        w_sel;
    logic            w_tmo_hit;
    logic            w_gap_hit;

    dac_rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_win),
        .o_vld (w_any)
    );

    // One-hot AND-OR mux of the winner's command word.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel.comm = i_req_comm[COMM_W*i +: COMM_W];
                w_sel.addr = i_req_addr[ADDR_W*i +: ADDR_W];
                w_sel.data = i_req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // The last count value is the one whose edge leaves the state, so counters never pass it.
    assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);
    assign w_gap_hit = (r_gap_cnt >= GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= PW'(NREQ - 1);
            r_tmo_cnt   <= '0;
            r_gap_cnt   <= '0;
            o_gnt       <= '0;
            o_dac_start <= 1'b0;
            o_dac_comm  <= '0;
            o_dac_addr  <= '0;
            o_dac_data  <= '0;
            o_busy      <= 1'b0;
            o_err_tmo   <= 1'b0;
`ifdef DAC_ARB_INIT_EN
            r_init_pend <= 1'b1;
`endif
        end else begin
            o_gnt       <= '0;
            o_dac_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
`ifdef DAC_ARB_INIT_EN
                    if (r_init_pend) begin
                        r_init_pend <= 1'b0;
                        o_dac_comm  <= INIT_CMD.comm;
                        o_dac_addr  <= INIT_CMD.addr;
                        o_dac_data  <= INIT_CMD.data;
                        o_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end else
`endif
                    if (w_any) begin
                        o_gnt      <= w_gnt;
                        r_ptr      <= w_win;
                        o_dac_comm <= w_sel.comm;
                        o_dac_addr <= w_sel.addr;
                        o_dac_data <= w_sel.data;
                        o_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    o_dac_start <= 1'b1;
                    r_tmo_cnt   <= '0;
                    r_state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (i_dac_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (w_tmo_hit) begin
                        o_err_tmo <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_dac_busy) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_gap_hit) begin
                        o_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
